// File: rtl/ldpc_feed.sv
// ldpc_feed: collects one LDPC codeword of LLRs from the deinterleaver, packs
// PACK LLRs per word into a two-bank ping-pong SRAM, and presents full banks
// to the decoder with a valid/done handshake.
module ldpc_feed #(
  parameter int WID    = 6,
  parameter int PACK   = 8,
  parameter int CW_LEN = 9216,
  parameter int AW     = 11
) (
  input  logic                clk6,
  input  logic                rst_n,
  input  logic                bidin_rdy,
  input  logic                bidin_ena_out,
  input  logic [WID-1:0]      bidin_dout,
  output logic                ldpc_req,
  output logic                buf_wr,
  output logic [AW:0]         buf_addr,
  output logic [WID*PACK-1:0] buf_data,
  output logic                cw_valid,
  output logic                cw_bank,
  input  logic                dec_done,
  output logic                feed_err
);

  localparam int SW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [SW-1:0] LAST_LANE = SW'(PACK - 1);
  localparam logic [AW-1:0] LAST_WORD = AW'(CW_LEN / PACK - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state_q, state_d;
  logic                  ldpc_req_q, ldpc_req_d;
  logic                  buf_wr_q, buf_wr_d;
  logic [AW:0]           buf_addr_q, buf_addr_d;
  logic [WID*PACK-1:0]   buf_data_q, buf_data_d;
  logic [WID*PACK-1:0]   pack_q, pack_d;
  logic [SW-1:0]         sample_cnt_q, sample_cnt_d;
  logic [AW-1:0]         word_idx_q, word_idx_d;
  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  cw_valid_q, cw_valid_d;
  logic                  feed_err_q, feed_err_d;

  // Next-state logic: fill FSM, word packing, bank flags and decoder handshake.
  always_comb begin
    state_d      = state_q;
    ldpc_req_d   = 1'b0;
    buf_wr_d     = 1'b0;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    pack_d       = pack_q;
    sample_cnt_d = sample_cnt_q;
    word_idx_d   = word_idx_q;
    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    cw_valid_d   = |full_q;
    feed_err_d   = feed_err_q;

    // The decoder releases the bank it was shown; a completion on the other
    // bank in the same cycle sets its own flag independently below.
    if (dec_done && cw_valid_q) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    case (state_q)
      IDLE: begin
        if (bidin_ena_out) begin
          feed_err_d = 1'b1;
        end
        if (bidin_rdy && !full_q[wr_bank_q]) begin
          ldpc_req_d   = 1'b1;
          state_d      = FILL;
          sample_cnt_d = '0;
          word_idx_d   = '0;
        end
      end
      FILL: begin
        if (bidin_ena_out) begin
          pack_d[int'(sample_cnt_q)*WID +: WID] = bidin_dout;
          if (sample_cnt_q == LAST_LANE) begin
            sample_cnt_d = '0;
            buf_wr_d     = 1'b1;
            buf_addr_d   = {wr_bank_q, word_idx_q};
            buf_data_d   = pack_d;
            if (word_idx_q == LAST_WORD) begin
              word_idx_d        = '0;
              full_d[wr_bank_q] = 1'b1;
              wr_bank_d         = ~wr_bank_q;
              state_d           = IDLE;
            end else begin
              word_idx_d = word_idx_q + AW'(1);
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset discards any partial codeword.
  always_ff @(posedge clk6 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ldpc_req_q   <= 1'b0;
      buf_wr_q     <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      pack_q       <= '0;
      sample_cnt_q <= '0;
      word_idx_q   <= '0;
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      cw_valid_q   <= 1'b0;
      feed_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ldpc_req_q   <= ldpc_req_d;
      buf_wr_q     <= buf_wr_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      pack_q       <= pack_d;
      sample_cnt_q <= sample_cnt_d;
      word_idx_q   <= word_idx_d;
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      cw_valid_q   <= cw_valid_d;
      feed_err_q   <= feed_err_d;
    end
  end

  assign ldpc_req = ldpc_req_q;
  assign buf_wr   = buf_wr_q;
  assign buf_addr = buf_addr_q;
  assign buf_data = buf_data_q;
  assign cw_valid = cw_valid_q;
  assign cw_bank  = rd_bank_q;
  assign feed_err = feed_err_q;

endmodule

// File: tb/tb_ldpc_feed.sv
// tb_ldpc_feed: directed bench for ldpc_feed with a queue-based model of the
// expected SRAM writes and a per-cycle compare process.
module tb_ldpc_feed;

  localparam int WID    = 6;
  localparam int PACK   = 8;
  localparam int CW_LEN = 9216;
  localparam int AW     = 11;
  localparam int WORDS  = CW_LEN / PACK;

  logic                clk6 = 1'b0;
  logic                rst_n;
  logic                bidin_rdy;
  logic                bidin_ena_out;
  logic [WID-1:0]      bidin_dout;
  logic                ldpc_req;
  logic                buf_wr;
  logic [AW:0]         buf_addr;
  logic [WID*PACK-1:0] buf_data;
  logic                cw_valid;
  logic                cw_bank;
  logic                dec_done;
  logic                feed_err;

  ldpc_feed #(.WID(WID), .PACK(PACK), .CW_LEN(CW_LEN), .AW(AW)) dut (
    .clk6          (clk6),
    .rst_n         (rst_n),
    .bidin_rdy     (bidin_rdy),
    .bidin_ena_out (bidin_ena_out),
    .bidin_dout    (bidin_dout),
    .ldpc_req      (ldpc_req),
    .buf_wr        (buf_wr),
    .buf_addr      (buf_addr),
    .buf_data      (buf_data),
    .cw_valid      (cw_valid),
    .cw_bank       (cw_bank),
    .dec_done      (dec_done),
    .feed_err      (feed_err)
  );

  // 10 ns block clock
  always #5 clk6 = ~clk6;

  typedef struct packed {
    logic [AW:0]         addr;
    logic [WID*PACK-1:0] data;
  } wr_t;

  int                  checks = 0;
  int                  errors = 0;
  logic [WID-1:0]      mLane[$];
  wr_t                 expQ[$];
  int                  mWord = 0;
  logic                mBank = 1'b0;
  logic [WID*PACK-1:0] lastData = '0;
  int                  wrCount = 0;
  int                  reqCount = 0;
  logic [AW:0]         firstAddr = '0;
  logic [WID*PACK-1:0] firstData = '0;
  bit                  mustValid = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted LLR joins the current word; a full word becomes an
  // expected write to {bank, word}, and a full codeword flips the bank.
  task automatic modelPush(input logic [WID-1:0] v);
    wr_t e;
    mLane.push_back(v);
    if (mLane.size() == PACK) begin
      e.data = '0;
      for (int k = 0; k < PACK; k++) e.data[k*WID +: WID] = mLane[k];
      e.addr = {mBank, AW'(mWord)};
      expQ.push_back(e);
      mLane.delete();
      mWord++;
      if (mWord == WORDS) begin
        mWord = 0;
        mBank = ~mBank;
      end
    end
  endtask

  task automatic modelReset();
    mLane.delete();
    expQ.delete();
    mWord    = 0;
    mBank    = 1'b0;
    lastData = '0;
  endtask

  // Compare process: every write must match the model's next expected word,
  // and buf_data must hold the last written word between writes.
  always @(negedge clk6) begin
    wr_t e;
    if (rst_n) begin
      if (ldpc_req) reqCount++;
      if (mustValid) checkOutput("cw_valid_hold", {63'd0, cw_valid}, 64'd1);
      if (buf_wr) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_write", {63'd0, buf_wr}, 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("wr_addr", {52'd0, buf_addr}, {52'd0, e.addr});
          checkOutput("wr_data", {16'd0, buf_data}, {16'd0, e.data});
          lastData = e.data;
          if (wrCount == 0) begin
            firstAddr = buf_addr;
            firstData = buf_data;
          end
          wrCount++;
        end
      end else begin
        checkOutput("data_hold", {16'd0, buf_data}, {16'd0, lastData});
      end
    end
  end

  task automatic waitReq(output bit got);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk6); #1;
      if (ldpc_req) got = 1'b1;
    end
  endtask

  // Feed nLlr LLRs of value (index mod 64), optionally with random one-cycle
  // gaps, optionally pulsing dec_done alongside the last LLR.
  task automatic applyStimulus(input int nLlr, input bit gaps, input bit doneAtEnd);
    for (int i = 0; i < nLlr; i++) begin
      @(posedge clk6); #1;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bidin_ena_out = 1'b0;
        dec_done      = 1'b0;
        @(posedge clk6); #1;
      end
      bidin_ena_out = 1'b1;
      bidin_dout    = WID'(i % 64);
      dec_done      = doneAtEnd && (i == nLlr - 1);
      modelPush(bidin_dout);
    end
    @(posedge clk6); #1;
    bidin_ena_out = 1'b0;
    dec_done      = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req"}, {63'd0, ldpc_req}, 64'd0);
    checkOutput({tag, "_wr"}, {63'd0, buf_wr}, 64'd0);
    checkOutput({tag, "_addr"}, {52'd0, buf_addr}, 64'd0);
    checkOutput({tag, "_data"}, {16'd0, buf_data}, 64'd0);
    checkOutput({tag, "_valid"}, {63'd0, cw_valid}, 64'd0);
    checkOutput({tag, "_bank"}, {63'd0, cw_bank}, 64'd0);
    checkOutput({tag, "_err"}, {63'd0, feed_err}, 64'd0);
  endtask

  initial begin
    bit got;
    int reqBefore;
    rst_n = 1'b0;
    bidin_rdy = 1'b0;
    bidin_ena_out = 1'b0;
    bidin_dout = '0;
    dec_done = 1'b0;
    #1;
    checkAllZero("reset");
    repeat (3) @(posedge clk6);
    #1 rst_n = 1'b1;

    // Codeword 1: continuous, bank 0
    @(posedge clk6); #1;
    bidin_rdy = 1'b1;
    @(posedge clk6); #1;
    checkOutput("req_latency", {63'd0, ldpc_req}, 64'd1);
    bidin_rdy = 1'b0;
    wrCount = 0;
    applyStimulus(CW_LEN, 1'b0, 1'b0);
    checkOutput("cw1_last_wr", {63'd0, buf_wr}, 64'd1);
    checkOutput("cw1_last_addr", {52'd0, buf_addr}, 64'h47F);
    checkOutput("cw1_valid_early", {63'd0, cw_valid}, 64'd0);
    @(posedge clk6); #1;
    checkOutput("cw1_valid", {63'd0, cw_valid}, 64'd1);
    checkOutput("cw1_bank", {63'd0, cw_bank}, 64'd0);
    checkOutput("cw1_wr_count", wrCount, WORDS);
    checkOutput("cw1_first_addr", {52'd0, firstAddr}, 64'h000);
    checkOutput("cw1_first_data", {16'd0, firstData}, 64'h1C61440C2040);
    checkOutput("req_pulses_1", reqCount, 1);

    // Codeword 2: gapped strobes, bank 1
    bidin_rdy = 1'b1;
    waitReq(got);
    checkOutput("cw2_req", {63'd0, got}, 64'd1);
    wrCount = 0;
    applyStimulus(CW_LEN, 1'b1, 1'b0);
    checkOutput("cw2_last_addr", {52'd0, buf_addr}, 64'hC7F);
    @(posedge clk6); #1;
    checkOutput("cw2_wr_count", wrCount, WORDS);
    checkOutput("cw2_first_addr", {52'd0, firstAddr}, 64'h800);
    checkOutput("cw2_bank", {63'd0, cw_bank}, 64'd0);

    // Both banks full: no request despite bidin_rdy
    reqBefore = reqCount;
    repeat (20) @(posedge clk6);
    #1;
    checkOutput("no_req_when_full", reqCount - reqBefore, 0);
    checkOutput("full_valid", {63'd0, cw_valid}, 64'd1);

    // Release bank 0: pointer moves to bank 1, request follows
    mustValid = 1'b1;
    dec_done = 1'b1;
    @(posedge clk6); #1;
    dec_done = 1'b0;
    checkOutput("done_bank", {63'd0, cw_bank}, 64'd1);
    checkOutput("done_valid", {63'd0, cw_valid}, 64'd1);
    waitReq(got);
    checkOutput("cw3_req", {63'd0, got}, 64'd1);
    bidin_rdy = 1'b0;

    // Codeword 3 into bank 0; last LLR coincides with dec_done for bank 1
    wrCount = 0;
    applyStimulus(CW_LEN, 1'b0, 1'b1);
    checkOutput("cw3_last_addr", {52'd0, buf_addr}, 64'h47F);
    checkOutput("cw3_bank_now", {63'd0, cw_bank}, 64'd0);
    @(posedge clk6); #1;
    checkOutput("cw3_first_addr", {52'd0, firstAddr}, 64'h000);
    checkOutput("cw3_valid", {63'd0, cw_valid}, 64'd1);
    checkOutput("cw3_bank", {63'd0, cw_bank}, 64'd0);

    // Stray strobes in IDLE
    bidin_ena_out = 1'b1;
    bidin_dout = 6'd21;
    repeat (3) @(posedge clk6);
    #1 bidin_ena_out = 1'b0;
    @(posedge clk6); #1;
    checkOutput("stray_err", {63'd0, feed_err}, 64'd1);

    // Codeword 4 into bank 1, aborted by reset at LLR 5000
    bidin_rdy = 1'b1;
    waitReq(got);
    checkOutput("cw4_req", {63'd0, got}, 64'd1);
    bidin_rdy = 1'b0;
    wrCount = 0;
    applyStimulus(5000, 1'b0, 1'b0);
    checkOutput("err_held", {63'd0, feed_err}, 64'd1);
    checkOutput("cw4_partial_count", wrCount, 624);
    mustValid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkAllZero("abort");
    modelReset();
    @(posedge clk6); #1;
    rst_n = 1'b1;

    // dec_done with cw_valid=0 is ignored
    @(posedge clk6); #1;
    dec_done = 1'b1;
    @(posedge clk6); #1;
    dec_done = 1'b0;
    @(posedge clk6); #1;
    checkOutput("idle_done_bank", {63'd0, cw_bank}, 64'd0);
    checkOutput("idle_done_valid", {63'd0, cw_valid}, 64'd0);

    // Codeword 5 after reset: bank 0 from address 0
    bidin_rdy = 1'b1;
    waitReq(got);
    checkOutput("cw5_req", {63'd0, got}, 64'd1);
    bidin_rdy = 1'b0;
    wrCount = 0;
    applyStimulus(CW_LEN, 1'b0, 1'b0);
    checkOutput("cw5_last_addr", {52'd0, buf_addr}, 64'h47F);
    @(posedge clk6); #1;
    checkOutput("cw5_first_addr", {52'd0, firstAddr}, 64'h000);
    checkOutput("cw5_wr_count", wrCount, WORDS);
    checkOutput("cw5_valid", {63'd0, cw_valid}, 64'd1);
    checkOutput("cw5_bank", {63'd0, cw_bank}, 64'd0);
    checkOutput("cw5_err", {63'd0, feed_err}, 64'd0);
    checkOutput("exp_queue_empty", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldpc_feed.md
Name: ldpc_feed

Overview:
- Downstream neighbour of the byte deinterleaver; generates its `ldpc_req` and consumes its `bidin_ena_out`/`bidin_dout` LLR stream.
- Collects one LDPC codeword of soft values per request and packs PACK LLRs per word.
- Writes the words into an external two-bank (ping-pong) codeword SRAM.
- Hands full banks to the LDPC decoder core with a valid/done handshake.

Parameters:
- WID, 6, LLR width in bits.
- PACK, 8, LLRs packed per SRAM word.
- CW_LEN, 9216, LLRs per codeword; must be a multiple of PACK.
- AW, 11, word-index width; 2^AW ≥ CW_LEN/PACK (1152).

Ports:
- clk6  in  1  block clock.
- rst_n  in  1  asynchronous active-low reset.
- bidin_rdy  in  1  deinterleaver has a codeword available.
- bidin_ena_out  in  1  LLR strobe from deinterleaver.
- bidin_dout  in  WID  LLR value.
- ldpc_req  out  1  one-cycle request for one codeword.
- buf_wr  out  1  SRAM write strobe.
- buf_addr  out  AW+1  {bank, word_idx}.
- buf_data  out  WID*PACK  packed LLR word.
- cw_valid  out  1  a full bank is ready for the decoder.
- cw_bank  out  1  bank index presented to the decoder.
- dec_done  in  1  one-cycle pulse: decoder finished with cw_bank.
- feed_err  out  1  sticky: LLR strobe arrived outside FILL.

Behaviour:
- Reset, asynchronous, all registers cleared:
  - ldpc_req=0, buf_wr=0, buf_addr=0, buf_data=0, cw_valid=0, cw_bank=0, feed_err=0.
  - state=IDLE, both banks empty, write bank=0, read bank=0.
  - Reset mid-FILL discards the partial codeword; no further writes.
- Bank status: two full flags. A bank is free when its full flag is 0 and it is not the current write target.
- State machine:
  - IDLE: when bidin_rdy=1 and the write bank is free, assert ldpc_req for exactly one cycle on the next clock, then go to FILL. Sample and LLR counters are cleared on entry.
  - FILL: each cycle with bidin_ena_out=1 captures bidin_dout into lane (sample_cnt mod PACK). Lane 0 is bits [WID-1:0] and the first LLR goes there; lane k is bits [WID*(k+1)-1:WID*k].
  - FILL, completing a word: on the PACK-th LLR of a word, the next cycle drives buf_wr=1 for one cycle with buf_addr={write bank, word_idx} and the packed data; word_idx then increments. Write latency is 1 cycle after the last lane.
  - FILL, completing the codeword: when the CW_LEN-th LLR is accepted, the final write issues the next cycle. On that same cycle the write bank's full flag is set and the write bank toggles; state returns to IDLE.
  - buf_data holds its last value when buf_wr=0.
- Strobe gaps: bidin_ena_out may drop for any number of cycles during FILL; counters hold.
- Stray strobes: bidin_ena_out=1 in IDLE is dropped and sets feed_err. feed_err clears only on reset.
- Decoder side:
  - cw_valid = OR of full flags, registered.
  - cw_bank = read bank pointer; the oldest full bank is presented first.
  - dec_done while cw_valid=1 clears the full flag of cw_bank and toggles the read pointer. cw_valid re-evaluates the next cycle.
  - dec_done while cw_valid=0 is ignored.
- Simultaneous events:
  - Codeword completion and dec_done in the same cycle: both take effect. Flags set and clear independently; with different banks, cw_valid stays 1.
  - With both banks full, IDLE waits and no ldpc_req is issued until a dec_done frees the write bank.
  - bidin_rdy=1 in FILL has no effect.
- Counters: sample counter wraps 0..PACK-1; word_idx runs 0..CW_LEN/PACK-1 and resets to 0 at codeword end.

Test Plan:
- Reset, then bidin_rdy=1 → ldpc_req one-cycle pulse 1 clock later. Feed 9216 LLRs of value 0..63 repeating, continuous → 1152 buf_wr pulses at addresses 0x000..0x47F. The first word has lane0=0 and lane7=7. cw_valid=1 and cw_bank=0 one cycle after the last write.
- Second codeword with random one-cycle gaps in bidin_ena_out → addresses 0x800..0xC7F, data unchanged by the gaps. Both banks full; bidin_rdy=1 raises no ldpc_req.
- dec_done with cw_bank=0 → cw_bank=1, cw_valid stays 1. The next ldpc_req issues; the new codeword targets bank 0.
- Final write of a codeword coincides with dec_done for the other bank → one flag cleared and one set, cw_valid continuously 1, no lost bank.
- bidin_ena_out=1 in IDLE → no buf_wr, feed_err=1 and held through later codewords. dec_done with cw_valid=0 → no state change.
- rst_n low at LLR 5000 of a fill → all outputs 0 immediately. After release, a new request writes from address 0x000 of bank 0.
